// File: rtl/cuboid_emitter.sv
// Streams the two-triangle-per-face vertex list of an axis-aligned cuboid.
// Bounds, face mask and colours are captured on start; output uses valid/ready.
module cuboid_emitter #(
   parameter int COORD_W   = 16,
   parameter int COLOR_W   = 16,
   parameter int Z_OFFSET  = 64,
   parameter int NUM_FACES = 6
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [COORD_W-1:0]             x_lo,
   input  logic [COORD_W-1:0]             x_hi,
   input  logic [COORD_W-1:0]             y_lo,
   input  logic [COORD_W-1:0]             y_hi,
   input  logic [COORD_W-1:0]             z_near,
   input  logic [COORD_W-1:0]             z_far,
   input  logic [NUM_FACES-1:0]           face_mask,
   input  logic [NUM_FACES*COLOR_W-1:0]   face_colors,
   output logic [3*COORD_W-1:0]           vertex,
   output logic [COLOR_W-1:0]             color,
   output logic                           new_triangle,
   output logic                           vertex_valid,
   input  logic                           vertex_ready,
   output logic                           busy,
   output logic                           done
);

   typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

   localparam logic signed [COORD_W-1:0] ZOFF = COORD_W'(Z_OFFSET);
   localparam logic [2:0] NO_FACE = 3'd6;

   state_t state, state_next;

   logic signed [COORD_W-1:0] x_lo_q, x_hi_q, y_lo_q, y_hi_q, z_near_q, z_far_q;
   logic [NUM_FACES-1:0]         mask_q;
   logic [NUM_FACES*COLOR_W-1:0] colors_q;

   logic [2:0] face;
   logic [2:0] vidx;
   logic [1:0] phase;
   logic       accept, fire, face_end;
   logic [2:0] face_next;

   // Lowest enabled face index at or above 'from'; NO_FACE when none remain.
   function automatic logic [2:0] first_from(input logic [NUM_FACES-1:0] m,
                                             input logic [3:0] from);
      logic [2:0] r;
      r = NO_FACE;
      for (int i = NUM_FACES - 1; i >= 0; i--) begin
         if (m[i] && (i >= int'(from))) r = 3'(i);
      end
      return r;
   endfunction

   assign accept    = (state == IDLE) && start;
   assign fire      = vertex_valid && vertex_ready;
   assign face_end  = fire && (vidx == 3'd5);
   assign face_next = first_from(mask_q, {1'b0, face} + 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = state;
      vertex_valid = 1'b0;
      done         = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               busy       = 1'b1;
               state_next = (face_mask != '0) ? EMIT : FINISH;
            end
         end
         EMIT: begin
            busy         = 1'b1;
            vertex_valid = 1'b1;
            if (face_end && (face_next == NO_FACE)) state_next = FINISH;
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         face  <= '0;
         vidx  <= '0;
         phase <= '0;
      end else if (accept) begin
         face  <= first_from(face_mask, 4'd0);
         vidx  <= '0;
         phase <= '0;
      end else if (fire) begin
         phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
         vidx  <= (vidx == 3'd5) ? 3'd0 : vidx + 3'd1;
         if (vidx == 3'd5) face <= face_next;
      end
   end

   // Operand capture: only meaningful while a stream is active, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         x_lo_q   <= x_lo;
         x_hi_q   <= x_hi;
         y_lo_q   <= y_lo;
         y_hi_q   <= y_hi;
         z_near_q <= z_near;
         z_far_q  <= z_far;
         mask_q   <= face_mask;
         colors_q <= face_colors;
      end
   end

   logic [5:0] tab_a, tab_b;
   logic       sel_a, sel_b;
   logic signed [COORD_W-1:0] vx, vy, vz;

   // Per-vertex hi/lo selectors for the two in-plane axes of the current face.
   always_comb begin
      if (face < 3'd2) begin
         tab_a = 6'b110010;
         tab_b = 6'b101100;
      end else begin
         tab_a = 6'b001110;
         tab_b = 6'b011100;
      end
      sel_a = tab_a[vidx];
      sel_b = tab_b[vidx];
   end

   always_comb begin
      vx = '0;
      vy = '0;
      vz = '0;
      case (face)
         3'd0, 3'd1: begin
            vx = sel_a ? x_hi_q : x_lo_q;
            vy = sel_b ? y_hi_q : y_lo_q;
            vz = (face == 3'd0) ? z_near_q : z_far_q;
         end
         3'd2, 3'd3: begin
            vx = (face == 3'd2) ? x_lo_q : x_hi_q;
            vy = sel_a ? y_hi_q : y_lo_q;
            vz = sel_b ? z_far_q : z_near_q;
         end
         3'd4, 3'd5: begin
            vx = sel_a ? x_hi_q : x_lo_q;
            vy = (face == 3'd4) ? y_hi_q : y_lo_q;
            vz = sel_b ? z_far_q : z_near_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      vertex       = '0;
      color        = '0;
      new_triangle = 1'b0;
      if (state == EMIT) begin
         vertex       = {vx, vy, vz + ZOFF};
         color        = colors_q[face*COLOR_W +: COLOR_W];
         new_triangle = (phase == 2'd0);
      end
   end

endmodule

// File: tb/tb_cuboid_emitter.sv
// Scoreboard bench for cuboid_emitter: expected vertices queued at start,
// compared against every valid output cycle, popped on handshake.
module tb_cuboid_emitter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] x_lo, x_hi, y_lo, y_hi, z_near, z_far;
   logic [5:0]  face_mask;
   logic [95:0] face_colors;
   logic [47:0] vertex;
   logic [15:0] color;
   logic        new_triangle, vertex_valid, vertex_ready, busy, done;

   cuboid_emitter dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x_lo(x_lo), .x_hi(x_hi), .y_lo(y_lo), .y_hi(y_hi),
      .z_near(z_near), .z_far(z_far),
      .face_mask(face_mask), .face_colors(face_colors),
      .vertex(vertex), .color(color), .new_triangle(new_triangle),
      .vertex_valid(vertex_valid), .vertex_ready(vertex_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [47:0] v;
      logic [15:0] c;
      logic        nt;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   fires, first_fire, last_fire;
   int   done_cnt = 0;
   int   done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq("busy_at_done", 64'(busy), 64'd0);
         end
         if (vertex_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_vertex", 64'd1, 64'd0);
            end else begin
               check_eq("vertex", 64'(vertex), 64'(exp_q[0].v));
               check_eq("color",  64'(color),  64'(exp_q[0].c));
               check_eq("new_tri", 64'(new_triangle), 64'(exp_q[0].nt));
               if (vertex_ready) begin
                  void'(exp_q.pop_front());
                  if (fires == 0) first_fire = cyc;
                  fires++;
                  last_fire = cyc;
               end
            end
         end
      end
   end

   task automatic push_expected(input logic [15:0] xl, xh, yl, yh, zn, zf,
                                input logic [5:0] m, input logic [95:0] cols);
      bit xy_a[6]   = '{0, 1, 0, 0, 1, 1};
      bit xy_b[6]   = '{0, 0, 1, 1, 0, 1};
      bit side_a[6] = '{0, 1, 1, 1, 0, 0};
      bit side_b[6] = '{0, 0, 1, 1, 1, 0};
      logic [15:0] px, py, pz;
      exp_t e;
      for (int f = 0; f < 6; f++) begin
         if (m[f]) begin
            for (int v = 0; v < 6; v++) begin
               case (f)
                  0, 1: begin
                     px = xy_a[v] ? xh : xl;
                     py = xy_b[v] ? yh : yl;
                     pz = (f == 0) ? zn : zf;
                  end
                  2, 3: begin
                     px = (f == 2) ? xl : xh;
                     py = side_a[v] ? yh : yl;
                     pz = side_b[v] ? zf : zn;
                  end
                  default: begin
                     px = side_a[v] ? xh : xl;
                     py = (f == 4) ? yh : yl;
                     pz = side_b[v] ? zf : zn;
                  end
               endcase
               e.v  = {px, py, 16'(pz + 16'd64)};
               e.c  = cols[f*16 +: 16];
               e.nt = (v % 3 == 0);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic drive_bounds(input logic [15:0] xl, xh, yl, yh, zn, zf,
                               input logic [5:0] m, input logic [95:0] cols);
      x_lo = xl; x_hi = xh; y_lo = yl; y_hi = yh; z_near = zn; z_far = zf;
      face_mask = m; face_colors = cols;
   endtask

   // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: ready high plus a
   // second start with different operands while the stream is running.
   task automatic run(input string name, input logic [15:0] xl, xh, yl, yh, zn, zf,
                      input logic [5:0] m, input logic [95:0] cols, input int mode);
      int acc, d0, nverts;
      bit seen;
      nverts = 6 * $countones(m);
      fires = 0;
      d0 = done_cnt;
      @(posedge clk); #1;
      drive_bounds(xl, xh, yl, yh, zn, zf, m, cols);
      vertex_ready = 1'b1;
      start = 1'b1;
      acc = cyc;
      push_expected(xl, xh, yl, yh, zn, zf, m, cols);
      @(negedge clk);
      check_eq({name, "_busy_accept"}, 64'(busy), 64'd1);
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         drive_bounds(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
                      6'h3F, {6{16'hBEEF}});
         vertex_ready = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
         if (mode == 2 && k == 5) start = 1'b1;
         @(negedge clk); #1;
         if (done_cnt != d0) seen = 1;
      end
      start = 1'b0;
      if (!seen) check_eq({name, "_timeout"}, 64'd0, 64'd1);
      check_eq({name, "_fires"}, 64'(fires), 64'(nverts));
      check_eq({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      check_eq({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
      if (nverts == 0) begin
         check_eq({name, "_done_cycle"}, 64'(done_cyc), 64'(acc + 1));
      end else begin
         check_eq({name, "_done_after_last"}, 64'(done_cyc), 64'(last_fire + 1));
         if (mode != 1) begin
            check_eq({name, "_first_cycle"}, 64'(first_fire), 64'(acc + 1));
            check_eq({name, "_last_cycle"}, 64'(last_fire), 64'(acc + nverts));
         end
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
   endtask

   localparam logic [95:0] COLS = {16'h2204, 16'h1404, 16'h0500, 16'h0300, 16'h0200, 16'h0400};

   initial begin
      int d0, acc;
      rst_n = 1'b0;
      start = 1'b0;
      vertex_ready = 1'b1;
      drive_bounds('0, '0, '0, '0, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 64'(vertex_valid), 64'd0);
      check_eq("rst_vertex", 64'(vertex), 64'd0);
      check_eq("rst_busy_done", 64'({busy, done, new_triangle}), 64'd0);
      check_eq("rst_color", 64'(color), 64'd0);
      rst_n = 1'b1;

      run("full", -16'sd16, 16'sd16, -16'sd32, 16'sd0, 16'sd176, 16'sd208, 6'h3F, COLS, 0);
      run("sparse", -16'sd16, 16'sd16, -16'sd32, 16'sd0, 16'sd176, 16'sd208, 6'b010001, COLS, 0);
      run("bp", -16'sd16, 16'sd16, -16'sd32, 16'sd0, 16'sd176, 16'sd208, 6'h3F, COLS, 1);
      run("empty", 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 6'h00, COLS, 0);
      run("restart", 16'sd5, -16'sd7, 16'sd9, -16'sd11, 16'sd100, 16'sd300, 6'h3F, COLS, 2);
      run("wrap", 16'sd40, -16'sd40, 16'sd8, 16'sd2, 16'sh7FF0, 16'sh8000, 6'b101010, COLS, 1);

      // Reset asserted while the 10th vertex is on the output.
      fires = 0;
      d0 = done_cnt;
      @(posedge clk); #1;
      drive_bounds(-16'sd16, 16'sd16, -16'sd32, 16'sd0, 16'sd176, 16'sd208, 6'h3F, COLS);
      vertex_ready = 1'b1;
      start = 1'b1;
      acc = cyc;
      push_expected(-16'sd16, 16'sd16, -16'sd32, 16'sd0, 16'sd176, 16'sd208, 6'h3F, COLS);
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < acc + 10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", 64'(vertex_valid), 64'd0);
      check_eq("midrst_vertex", 64'(vertex), 64'd0);
      check_eq("midrst_outs", 64'({busy, done, new_triangle}), 64'd0);
      check_eq("midrst_color", 64'(color), 64'd0);
      check_eq("midrst_fires", 64'(fires), 64'd9);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      check_eq("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      run("after_rst", -16'sd16, 16'sd16, -16'sd32, 16'sd0, 16'sd176, 16'sd208, 6'h3F, COLS, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
